// File: rtl/tpu_matmul_sequencer_pkg.sv
// Shared types and run-length helpers for the systolic matmul sequencer and the MMIO decode.
package tpu_matmul_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Cycles needed to push DIM operand skews through the array and drain the last products.
  function automatic int unsigned run_cycles(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned dim);
    return $clog2(3 * dim - 1);
  endfunction

endpackage

// File: rtl/tpu_matmul_sequencer_if.sv
// Control/status bundle between the MMIO decoder (master) and the matmul sequencer (slave).
interface tpu_matmul_sequencer_if #(
  parameter int unsigned CNTW = 5
);

  logic            start;
  logic            abort;
  logic            host_req;
  logic            clr_err;
  logic            host_grant;
  logic            host_stall;
  logic            mem_shift_en;
  logic            sa_en;
  logic            ab_zero_pad;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] cycle_cnt;
  logic            err_start_busy;

  modport master (
    output start, abort, host_req, clr_err,
    input  host_grant, host_stall, mem_shift_en, sa_en, ab_zero_pad,
           busy, done, cycle_cnt, err_start_busy
  );

  modport slave (
    input  start, abort, host_req, clr_err,
    output host_grant, host_stall, mem_shift_en, sa_en, ab_zero_pad,
           busy, done, cycle_cnt, err_start_busy
  );

endinterface

// File: rtl/tpu_matmul_sequencer.sv
// Sequences one systolic matmul (FILL then DRAIN, 3*DIM-2 cycles, then a DONE pulse)
// and arbitrates host access to memA/memB/C against the running matmul. DIM must be >= 2.
module tpu_matmul_sequencer
  import tpu_matmul_sequencer_pkg::*;
#(
  parameter int unsigned DIM  = 8,
  parameter int unsigned CNTW = cnt_width(DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tpu_matmul_sequencer_if.slave  seq
);

  localparam int unsigned RUN_CYC   = run_cycles(DIM);
  localparam logic [CNTW-1:0] FILL_LAST = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(RUN_CYC - 1);

  seq_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            run_c;
  logic            idle_or_done_c;

  // State, cycle counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter and error update; abort outranks start while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (seq.start) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (seq.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == FILL_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (seq.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == RUN_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = seq.start ? FILL : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A fresh error wins over a same-cycle clear.
    if (seq.clr_err) begin
      err_d = 1'b0;
    end
    if (seq.start && run_c) begin
      err_d = 1'b1;
    end
  end

  assign run_c          = (state_q == FILL) || (state_q == DRAIN);
  assign idle_or_done_c = (state_q == IDLE) || (state_q == DONE);

  // Datapath controls decode straight from the registered state.
  assign seq.busy           = run_c;
  assign seq.mem_shift_en   = run_c;
  assign seq.sa_en          = run_c;
  assign seq.ab_zero_pad    = (state_q == DRAIN);
  assign seq.done           = (state_q == DONE);
  assign seq.cycle_cnt      = run_c ? cnt_q : '0;
  assign seq.err_start_busy = err_q;

  // Host access follows the current state so a same-cycle start still grants the host.
  assign seq.host_grant = seq.host_req & idle_or_done_c;
  assign seq.host_stall = seq.host_req & run_c;

  a_grant_stall_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(seq.host_grant && seq.host_stall));

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= RUN_LAST);

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Cycle-level scoreboard bench for tpu_matmul_sequencer at DIM=8 (22-cycle runs).
module tb_tpu_matmul_sequencer;

  localparam int unsigned DIM  = 8;
  localparam int unsigned CNTW = 5;
  localparam int          RUN  = 22;
  localparam int          PAD0 = 9;

  typedef struct packed {
    logic            grant;
    logic            stall;
    logic            shift;
    logic            sa;
    logic            pad;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] cnt;
    logic            err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tpu_matmul_sequencer_if #(.CNTW(CNTW)) seq_if ();

  tpu_matmul_sequencer #(.DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (seq_if.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t sb_q[$];

  // Reference: k = cycles since the run was accepted (0 = no run, 1..22 running, 23 = done).
  int   k_m   = 0;
  bit   err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t expect_now(input bit hr);
    obs_t e;
    bit   run;
    run     = (k_m >= 1) && (k_m <= RUN);
    e.busy  = run;
    e.shift = run;
    e.sa    = run;
    e.pad   = (k_m >= PAD0) && (k_m <= RUN);
    e.done  = (k_m == RUN + 1);
    e.cnt   = run ? CNTW'(k_m - 1) : '0;
    e.err   = err_m;
    e.grant = hr && !run;
    e.stall = hr && run;
    return e;
  endfunction

  task automatic compare_obs(input string tag);
    obs_t e;
    e = sb_q.pop_front();
    check_eq({tag, ".grant"}, 32'(seq_if.host_grant),     32'(e.grant));
    check_eq({tag, ".stall"}, 32'(seq_if.host_stall),     32'(e.stall));
    check_eq({tag, ".shift"}, 32'(seq_if.mem_shift_en),   32'(e.shift));
    check_eq({tag, ".sa"},    32'(seq_if.sa_en),          32'(e.sa));
    check_eq({tag, ".pad"},   32'(seq_if.ab_zero_pad),    32'(e.pad));
    check_eq({tag, ".busy"},  32'(seq_if.busy),           32'(e.busy));
    check_eq({tag, ".done"},  32'(seq_if.done),           32'(e.done));
    check_eq({tag, ".cnt"},   32'(seq_if.cycle_cnt),      32'(e.cnt));
    check_eq({tag, ".err"},   32'(seq_if.err_start_busy), 32'(e.err));
  endtask

  // One clock: drive inputs, queue expected outputs, compare, then advance the reference.
  task automatic step(input string tag, input bit st, input bit ab, input bit hr, input bit ce);
    bit run;
    @(negedge clk);
    seq_if.start    = st;
    seq_if.abort    = ab;
    seq_if.host_req = hr;
    seq_if.clr_err  = ce;
    sb_q.push_back(expect_now(hr));
    #1;
    compare_obs(tag);
    run = (k_m >= 1) && (k_m <= RUN);
    if (st && run)   err_m = 1'b1;
    else if (ce)     err_m = 1'b0;
    if (run)         k_m = ab ? 0 : k_m + 1;
    else             k_m = st ? 1 : 0;
  endtask

  task automatic idle_inputs();
    seq_if.start    = 1'b0;
    seq_if.abort    = 1'b0;
    seq_if.host_req = 1'b0;
    seq_if.clr_err  = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    k_m   = 0;
    err_m = 1'b0;
    sb_q.push_back(expect_now(1'b0));
    #1;
    compare_obs(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    sb_q.push_back(expect_now(1'b0));
    #1;
    compare_obs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, 0, 0);

    // Plain run: start at cycle 0, done at 23.
    step("t1", 1, 0, 0, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t1", 0, 0, 0, 0);
    step("t1.after", 0, 0, 0, 0);

    // Host held through a run; start and host_req together at cycle 0.
    step("t2", 1, 0, 1, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t2", 0, 0, 1, 0);
    step("t2.after", 0, 0, 1, 0);

    // Start while busy is ignored and sets the sticky error until cleared.
    step("t3", 1, 0, 0, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t3", i == 5, 0, 0, 0);
    step("t3.hold", 0, 0, 0, 0);
    step("t3.clr", 0, 0, 0, 1);
    step("t3.cleared", 0, 0, 0, 0);

    // Back-to-back runs from the DONE cycle; clear and new error in the same cycle.
    step("t4", 1, 0, 0, 0);
    for (int i = 1; i <= RUN; i++) step("t4.a", 0, 0, 0, 0);
    step("t4.done_start", 1, 0, 0, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t4.b", i == 3, 0, 0, i == 3);
    step("t4.clr", 0, 0, 0, 1);

    // Abort at run cycle 10 (abort+start together), abort in IDLE, abort in DONE with start.
    step("t5", 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step("t5", 0, 0, 0, 0);
    step("t5.abort", 1, 1, 0, 0);
    step("t5.idle", 0, 0, 0, 1);
    step("t5.restart", 1, 0, 0, 0);
    for (int i = 1; i <= RUN; i++) step("t5.run", 0, 0, 0, 0);
    step("t5.done_abort", 1, 1, 0, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t5.run2", 0, 0, 0, 0);
    step("t5.idle_abort", 0, 1, 0, 0);

    // Reset mid-run clears everything including the sticky error.
    step("t6", 1, 0, 0, 0);
    for (int i = 1; i <= 14; i++) step("t6", i == 3, 0, 0, 0);
    apply_reset("t6.rst");
    step("t6.grant", 0, 0, 1, 0);
    step("t6.run", 1, 0, 0, 0);
    for (int i = 1; i <= RUN + 1; i++) step("t6.run", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
